// File: rtl/ps2_rx_fifo_if.sv
// Read-side bus of the PS/2 receiver FIFO: pop/clear requests and head/status.
interface ps2_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 8
) ();
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          read_enable;
  logic          ovf_clr;
  logic [7:0]    data;
  logic          ready;
  logic [LW-1:0] level;
  logic          overflow;
  logic          frame_err;
  logic          parity_err;

  // Receiver side drives the status, consumer side drives the requests.
  modport master (
    input  read_enable, ovf_clr,
    output data, ready, level, overflow, frame_err, parity_err
  );

  modport slave (
    output read_enable, ovf_clr,
    input  data, ready, level, overflow, frame_err, parity_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a first-word fall-through byte FIFO.
// Optional macro PS2_PARITY_EN: reject frames that fail the odd-parity check.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_fifo_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          fall_c, sdata_c;

  state_t        state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push_c, ferr_c;
`ifdef PS2_PARITY_EN
  logic          parity_q, parity_d;
  logic          perr_c;
  logic          parity_err_q;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] level_q, level_d;
  logic          ready_q, overflow_q, frame_err_q;
  logic          full_c, pop_c, wr_c, drop_c;

  // Two-flop synchronizers plus the previous synchronized clock for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall_c  = clk_prev & ~clk_sync[1];
  assign sdata_c = data_sync[1];

  // Receive FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tmo_q     <= '0;
`ifdef PS2_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
`ifdef PS2_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Frame decoding on ps2_clk falling edges; inactivity timeout while a frame is open.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tmo_d     = '0;
    push_c    = 1'b0;
    ferr_c    = 1'b0;
`ifdef PS2_PARITY_EN
    parity_d  = parity_q;
    perr_c    = 1'b0;
`endif
    if (fall_c) begin
      unique case (state_q)
        IDLE: begin
          if (!sdata_c) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
        DATA: begin
          shift_d = {sdata_c, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d   = PARITY;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        PARITY: begin
`ifdef PS2_PARITY_EN
          parity_d = sdata_c;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!sdata_c) begin
            ferr_c = 1'b1;
          end else begin
`ifdef PS2_PARITY_EN
            if (^{shift_q, parity_q}) push_c = 1'b1;
            else                      perr_c = 1'b1;
`else
            push_c = 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        bit_idx_d = 3'd0;
        ferr_c    = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign full_c = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_c  = bus.read_enable & ready_q;
  assign wr_c   = push_c & (~full_c | pop_c);
  assign drop_c = push_c & full_c & ~pop_c;

  // Next entry count after this cycle's push/pop.
  always_comb begin
    level_d = level_q;
    if (wr_c && !pop_c)      level_d = level_q + PW'(1);
    else if (!wr_c && pop_c) level_d = level_q - PW'(1);
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr[AW-1:0]] <= shift_q;
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_c)  wr_ptr <= wr_ptr + PW'(1);
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      level_q     <= level_d;
      ready_q     <= (level_d != '0);
      frame_err_q <= ferr_c;
      if (drop_c)           overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

`ifdef PS2_PARITY_EN
  // Parity failure pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= perr_c;
  end
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data      = mem[rd_ptr[AW-1:0]];
  assign bus.ready     = ready_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames, keeps a queue model of the FIFO.
module tb_ps2_rx_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 200;
  localparam int          H     = 4;   // clk cycles per ps2_clk half period
  localparam int          LAT   = 3;   // 2-flop sync + edge detect before the FSM acts

  typedef struct {int at; int kind; logic [7:0] b;} ev_t;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, fe_cnt = 0, pe_cnt = 0;
  bit fe_dc = 1'b0, rand_rd = 1'b0;
  int rd_div = 3;
  logic [7:0] q[$];
  ev_t evq[$];
  bit m_ovf = 1'b0, m_fe = 1'b0, m_pe = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue updated at each clk edge from frame outcomes.
  always @(posedge clk) begin
    bit push, fe, pe, pop, drop;
    logic [7:0] pb;
    ev_t e;
    cyc++;
    if (rst) begin
      q.delete(); evq.delete();
      m_ovf = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    end else begin
      push = 1'b0; fe = 1'b0; pe = 1'b0; pb = 8'h00;
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        e = evq.pop_front();
        case (e.kind)
          0:       begin push = 1'b1; pb = e.b; end
          1:       fe = 1'b1;
          default: pe = 1'b1;
        endcase
      end
      pop  = bus.read_enable && (q.size() > 0);
      drop = push && (q.size() == int'(DEPTH)) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(pb);
      if (drop) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      m_fe = fe;
      m_pe = pe;
    end
  end

  // Cycle-by-cycle compare of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("ready", int'(bus.ready), int'(q.size() != 0));
      chk("level", int'(bus.level), q.size());
      if (q.size() > 0) chk("data", int'(bus.data), int'(q[0]));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      if (!fe_dc) chk("frame_err", int'(bus.frame_err), int'(m_fe));
      chk("parity_err", int'(bus.parity_err), int'(m_pe));
      if (bus.frame_err === 1'b1) fe_cnt++;
      if (bus.parity_err === 1'b1) pe_cnt++;
    end
  end

  task automatic step(input bit pc, input bit pd, input bit pop, input bit clr);
    @(negedge clk);
    ps2_clk  = pc;
    ps2_data = pd;
    if (rand_rd) begin
      bus.read_enable = ($urandom_range(0, rd_div - 1) == 0);
      bus.ovf_clr     = ($urandom_range(0, 63) == 0);
    end else begin
      bus.read_enable = pop;
      bus.ovf_clr     = clr;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Sends the first n bits of a frame (bit 0 = start); the stop edge schedules its outcome.
  task automatic send_raw(input logic [10:0] bits, input int n, input int kind, input bit pop_at_push);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < H; j++) step(1'b1, bits[i], 1'b0, 1'b0);
      for (int j = 0; j < H; j++) begin
        step(1'b0, bits[i], pop_at_push && i == 10 && j == LAT - 1, 1'b0);
        if (i == 10 && j == 0) begin
          e.at = cyc + LAT; e.kind = kind; e.b = bits[8:1];
          evq.push_back(e);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input bit pop_at_push);
    int kind;
    kind = stop ? 0 : 1;
`ifdef PS2_PARITY_EN
    if (stop && ((^b) ^ par) == 1'b0) kind = 2;
`endif
    send_raw({stop, par, b, 1'b0}, 11, kind, pop_at_push);
    idle(2 * H);
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("pop_data", int'(bus.data), int'(exp));
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 2 && q.size() > 0; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, p0;
    logic [7:0] b;
    bit st, par;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    bus.read_enable = 1'b0; bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_parity_err", int'(bus.parity_err), 0);
    rst = 1'b0;
    idle(4);

    // Single frame then one pop.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("f1c_ready", int'(bus.ready), 1);
    chk("f1c_data", int'(bus.data), 8'h1C);
    chk("f1c_level", int'(bus.level), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("f1c_pop_ready", int'(bus.ready), 0);
    chk("f1c_pop_level", int'(bus.level), 0);

    // Bad stop bit.
    f0 = fe_cnt;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("stop0_fe_pulses", fe_cnt - f0, 1);
    chk("stop0_level", int'(bus.level), 0);

    // Wrong parity.
    p0 = pe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_EN
    chk("par_pe_pulses", pe_cnt - p0, 1);
    chk("par_level", int'(bus.level), 0);
`else
    chk("par_pe_pulses", pe_cnt - p0, 0);
    chk("par_level", int'(bus.level), 1);
    chk("par_data", int'(bus.data), 8'h1C);
`endif
    drain();

    // Overflow: nine frames into eight entries.
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_frame(b, ~^b, 1'b1, 1'b0);
    end
    chk("ovf_level", int'(bus.level), 8);
    chk("ovf_flag", int'(bus.overflow), 1);
    for (int i = 1; i <= 8; i++) pop_chk(8'(i));
    idle(1);
    chk("ovf_drained", int'(bus.level), 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("ovf_cleared", int'(bus.overflow), 0);

    // Push into a full FIFO in the same cycle as a pop.
    for (int i = 0; i < 8; i++) begin
      b = 8'h11 + 8'(i);
      send_frame(b, ~^b, 1'b1, 1'b0);
    end
    chk("full_level", int'(bus.level), 8);
    send_frame(8'h19, ~^8'h19, 1'b1, 1'b1);
    chk("pp_level", int'(bus.level), 8);
    chk("pp_overflow", int'(bus.overflow), 0);
    chk("pp_head", int'(bus.data), 8'h12);
    for (int i = 0; i < 8; i++) pop_chk(8'h12 + 8'(i));
    idle(1);
    chk("pp_drained", int'(bus.level), 0);

    // Timeout after start + 3 data bits, then a clean frame.
    f0 = fe_cnt;
    send_raw({2'b11, 8'hAA, 1'b0}, 4, 0, 1'b0);
    fe_dc = 1'b1;
    idle(int'(TMO) + 5);
    fe_dc = 1'b0;
    chk("tmo_fe_pulses", fe_cnt - f0, 1);
    send_frame(8'hF0, ~^8'hF0, 1'b1, 1'b0);
    chk("tmo_next_level", int'(bus.level), 1);
    chk("tmo_next_data", int'(bus.data), 8'hF0);
    drain();

    // Reset in the middle of a frame.
    send_raw({2'b11, 8'h3C, 1'b0}, 5, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
    send_frame(8'h81, ~^8'h81, 1'b1, 1'b0);
    chk("rstmid_level", int'(bus.level), 1);
    chk("rstmid_data", int'(bus.data), 8'h81);
    drain();

    // Randomized traffic: slow reader (fills/overflows), then fast reader.
    rand_rd = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rd_div = (i < 25) ? 40 : 3;
      b   = 8'($urandom);
      st  = ($urandom_range(0, 7) != 0);
      par = ($urandom_range(0, 7) == 0) ? ^b : ~^b;
      send_frame(b, par, st, 1'b0);
      idle(int'($urandom_range(0, 12)));
    end
    rand_rd = 1'b0;
    drain();
    chk("end_level", int'(bus.level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
